// File: rtl/mod3_word_serializer.sv
// Word-to-serial feeder for the divisible-by-3 detector: clears the detector, shifts the
// accepted word in MSB-first, then captures the detector's verdict as a one-cycle result.
module mod3_word_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_clr,
    output logic             ser_out,
    input  logic             mod3_in,
    output logic             res_valid,
    output logic             res_div3,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        SHIFT  = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_bit_s;

    // Next-state decode; the count marks the edge that consumes the final bit.
    always_comb begin
        state_s    = state_r;
        last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = CLR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                state_s = SHIFT;
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            SAMPLE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register, bit counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            res_valid <= 1'b0;
            res_div3  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shreg_r <= in_data;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                SAMPLE: begin
                    res_valid <= 1'b1;
                    res_div3  <= mod3_in;
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    // The detector clear follows rst directly so both blocks leave reset together.
    always_comb begin
        in_ready = (state_r == IDLE) && !rst;
        ser_clr  = (state_r == CLR) || rst;
        busy     = (state_r != IDLE);
        if (state_r == SHIFT) begin
            ser_out = shreg_r[WIDTH-1];
        end else begin
            ser_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_mod3_word_serializer.sv
// Bench for mod3_word_serializer: WIDTH=8 and WIDTH=3 instances, each driving a behavioural
// detector, checked every cycle against an age-based word model plus literal expectations.
module tb_mod3_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv [2];
    logic [7:0] d8;
    logic [2:0] d3;
    logic       rdy [2];
    logic       clr [2];
    logic       so  [2];
    logic       m3  [2];
    logic       rv  [2];
    logic       rd  [2];
    logic       bsy [2];

    int  rem [2] = '{0, 0};
    int  age [2] = '{0, 0};
    int  word [2];
    logic erv [2];
    logic ediv [2];
    int  cyc = 0;
    bit  started = 1'b0;

    int nvec = 0;
    int nfail = 0;
    int res_cnt [2] = '{0, 0};
    int last_div [2] = '{0, 0};
    int prev_div [2] = '{0, 0};
    int last_lat [2] = '{0, 0};
    int acc_prev [2] = '{0, 0};
    int acc_last [2] = '{0, 0};
    int clr_cnt [2] = '{0, 0};
    int seq [2] = '{0, 0};

    always #5 clk = ~clk;

    mod3_word_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(d8),
        .ser_clr(clr[0]), .ser_out(so[0]), .mod3_in(m3[0]),
        .res_valid(rv[0]), .res_div3(rd[0]), .busy(bsy[0])
    );

    mod3_word_serializer #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(d3),
        .ser_clr(clr[1]), .ser_out(so[1]), .mod3_in(m3[1]),
        .res_valid(rv[1]), .res_div3(rd[1]), .busy(bsy[1])
    );

    function automatic int wof(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Serial detector: running remainder of the bits consumed since the last clear.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rem[i] <= clr[i] ? 0 : (rem[i] * 2 + int'(so[i])) % 3;
        end
    end
    assign m3[0] = (rem[0] == 0);
    assign m3[1] = (rem[1] == 0);

    // Word model: age counts edges since accept; result due WIDTH+2 edges later.
    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                age[i]  = 0;
                erv[i]  = 1'b0;
                ediv[i] = 1'b0;
            end else begin
                erv[i] = 1'b0;
                if (age[i] == wof(i) + 2) begin
                    erv[i]  = 1'b1;
                    ediv[i] = (word[i] % 3 == 0);
                    age[i]  = 0;
                end else if (age[i] != 0) begin
                    age[i]++;
                end else if (iv[i] === 1'b1) begin
                    word[i] = (i == 0) ? int'(d8) : int'(d3);
                    age[i]  = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus capture of observed behaviour.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                int  w;
                logic ebit;
                w = wof(i);
                ebit = (age[i] >= 2 && age[i] <= w + 1) ? 1'((word[i] >> (w + 1 - age[i])) & 1) : 1'b0;
                chk($sformatf("in_ready[%0d]", i), rdy[i], (age[i] == 0) && !rst);
                chk($sformatf("ser_clr[%0d]", i), clr[i], (age[i] == 1) || rst);
                chk($sformatf("ser_out[%0d]", i), so[i], ebit);
                chk($sformatf("busy[%0d]", i), bsy[i], age[i] != 0);
                chk($sformatf("res_valid[%0d]", i), rv[i], erv[i]);
                chk($sformatf("res_div3[%0d]", i), rd[i], ediv[i]);
                if (rdy[i] === 1'b1 && iv[i] === 1'b1) begin
                    acc_prev[i] = acc_last[i];
                    acc_last[i] = cyc + 1;
                end
                if (clr[i] === 1'b1 && rst === 1'b0) clr_cnt[i]++;
                if (age[i] == 1) seq[i] = 0;
                if (age[i] >= 2 && age[i] <= w + 1) seq[i] = seq[i] * 2 + int'(so[i]);
                if (rv[i] === 1'b1) begin
                    res_cnt[i]++;
                    prev_div[i] = last_div[i];
                    last_div[i] = int'(rd[i]);
                    last_lat[i] = cyc - acc_last[i];
                end
            end
        end
    end

    task automatic send(input int i, input int data, input int waitc);
        @(posedge clk);
        #1;
        iv[i] = 1'b1;
        if (i == 0) d8 = data[7:0];
        else        d3 = data[2:0];
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        repeat (waitc) @(posedge clk);
        #1;
    endtask

    initial begin
        int vals [4] = '{10, 0, 255, 254};
        int exps [4] = '{0, 1, 1, 0};
        logic [7:0] tbl3;
        int rc0;
        tbl3 = 8'b0100_1001;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        d8 = 8'd0;
        d3 = 3'd0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ser_clr", clr[0], 1);
        chk("rst_in_ready", rdy[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", bsy[0], 0);
        chk("post_rst_in_ready", rdy[0], 1);
        chk("post_rst_res_valid", rv[0], 0);
        chk("post_rst_res_div3", rd[0], 0);

        send(0, 9, 11);
        chk("w9_ser_seq", seq[0], 32'd9);
        chk("w9_div3", last_div[0], 1);
        chk("w9_latency", last_lat[0], 10);
        chk("w9_res_count", res_cnt[0], 1);

        for (int k = 0; k < 4; k++) begin
            send(0, vals[k], 11);
            chk($sformatf("w%0d_div3", vals[k]), last_div[0], exps[k]);
            chk($sformatf("w%0d_res_count", vals[k]), res_cnt[0], 2 + k);
        end

        clr_cnt[0] = 0;
        rc0 = res_cnt[0];
        @(posedge clk);
        #1 iv[0] = 1'b1; d8 = 8'd3;
        @(posedge clk);
        #1 d8 = 8'd4;
        repeat (11) @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_spacing", acc_last[0] - acc_prev[0], 11);
        chk("b2b_res_count", res_cnt[0] - rc0, 2);
        chk("b2b_first_div3", prev_div[0], 1);
        chk("b2b_second_div3", last_div[0], 0);
        chk("b2b_clr_pulses", clr_cnt[0], 2);

        rc0 = res_cnt[0];
        @(posedge clk);
        #1 iv[0] = 1'b1; d8 = 8'd6;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", bsy[0], 0);
        chk("abort_in_ready", rdy[0], 1);
        chk("abort_res_valid", rv[0], 0);
        chk("abort_res_div3", rd[0], 0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_result", res_cnt[0], rc0);
        send(0, 7, 11);
        chk("w7_div3", last_div[0], 0);
        chk("w7_res_count", res_cnt[0], rc0 + 1);

        rc0 = res_cnt[0];
        @(posedge clk);
        #1 iv[0] = 1'b1; d8 = 8'd12;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            iv[0] = (k % 2 == 0);
            d8 = 8'(k * 37 + 1);
            @(posedge clk);
        end
        #1 iv[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("busy_ignore_res_count", res_cnt[0], rc0 + 1);
        chk("busy_ignore_div3", last_div[0], 1);

        for (int v = 0; v < 8; v++) begin
            send(1, v, 6);
            chk($sformatf("w3_%0d_div3", v), last_div[1], tbl3[v]);
            chk($sformatf("w3_%0d_latency", v), last_lat[1], 5);
        end
        chk("w3_res_count", res_cnt[1], 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
